// File: rtl/led_bar_sequencer.sv
// LED bar sequencer: an Avalon-MM write master that owns the LED PIO.
// Two requesters compete for the LEDs: a thermometer-coded temperature
// level and an over-temperature blink pattern, which has priority. A
// single-cycle PIO write is issued only when the wanted pattern differs
// from the last value written (the shadow register).
module led_bar_sequencer #(
    parameter int LED_WIDTH = 10,
    parameter int LEVEL_W   = 4,
    parameter int BLINK_DIV = 25000000,
    parameter int PIO_ADDR  = 0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [LEVEL_W-1:0] level_in,
    input  logic               level_valid,
    input  logic               alarm,
    input  logic               hold,
    output logic [1:0]         pio_address,
    output logic               pio_chipselect,
    output logic               pio_write_n,
    output logic [31:0]        pio_writedata,
    output logic               busy,
    output logic [15:0]        write_count
);

    localparam int                  CNT_W     = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0]    CNT_MAX   = CNT_W'(BLINK_DIV - 1);
    localparam logic [LEVEL_W-1:0]  LEVEL_MAX = LEVEL_W'(LED_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [LEVEL_W-1:0]   level_q, level_d;
    logic [CNT_W-1:0]     blink_cnt_q, blink_cnt_d;
    logic                 blink_phase_q, blink_phase_d;
    logic [LED_WIDTH-1:0] shadow_q, shadow_d;
    logic [LED_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [15:0]          count_q, count_d;
    logic                 cs_q, cs_d;
    logic                 wn_q, wn_d;
    logic [31:0]          wd_q, wd_d;
    logic                 busy_q, busy_d;
    logic [LED_WIDTH-1:0] bar_s;
    logic [LED_WIDTH-1:0] target_s;

    // Level capture with saturation at the number of LEDs.
    always_comb begin
        level_d = level_q;
        if (level_valid) begin
            if (level_in > LEVEL_MAX) begin
                level_d = LEVEL_MAX;
            end else begin
                level_d = level_in;
            end
        end else begin
            level_d = level_q;
        end
    end

    // Blink timer: free-runs only while the alarm is raised and restarts in
    // the "on" phase so every alarm begins with all LEDs lit.
    always_comb begin
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (alarm) begin
            if (blink_cnt_q == CNT_MAX) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d   = blink_cnt_q + CNT_W'(1);
            end
        end else begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b1;
        end
    end

    // Wanted LED pattern: blink pattern while alarmed, otherwise the bar.
    always_comb begin
        bar_s = '0;
        for (int i = 0; i < LED_WIDTH; i++) begin
            bar_s[i] = (i < int'(level_q));
        end
        if (alarm) begin
            if (blink_phase_q) begin
                target_s = '1;
            end else begin
                target_s = '0;
            end
        end else begin
            target_s = bar_s;
        end
    end

    // Write sequencer next-state; strobes are computed for the next state so
    // that they leave the chip straight from flops.
    always_comb begin
        state_d   = state_q;
        wr_data_d = wr_data_q;
        shadow_d  = shadow_q;
        count_d   = count_q;
        cs_d      = 1'b0;
        wn_d      = 1'b1;
        wd_d      = 32'd0;
        busy_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if ((target_s != shadow_q) && !hold) begin
                    state_d   = ST_WRITE;
                    wr_data_d = target_s;
                    cs_d      = 1'b1;
                    wn_d      = 1'b0;
                    wd_d      = 32'(target_s);
                    busy_d    = 1'b1;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_WRITE: begin
                shadow_d = wr_data_q;
                count_d  = count_q + 16'd1;
                state_d  = ST_SETTLE;
                busy_d   = 1'b1;
            end
            ST_SETTLE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, datapath and registered output flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            level_q       <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
            shadow_q      <= '0;
            wr_data_q     <= '0;
            count_q       <= 16'd0;
            cs_q          <= 1'b0;
            wn_q          <= 1'b1;
            wd_q          <= 32'd0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            level_q       <= level_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            shadow_q      <= shadow_d;
            wr_data_q     <= wr_data_d;
            count_q       <= count_d;
            cs_q          <= cs_d;
            wn_q          <= wn_d;
            wd_q          <= wd_d;
            busy_q        <= busy_d;
        end
    end

    assign pio_address    = 2'(PIO_ADDR);
    assign pio_chipselect = cs_q;
    assign pio_write_n    = wn_q;
    assign pio_writedata  = wd_q;
    assign busy           = busy_q;
    assign write_count    = count_q;

endmodule

// File: tb/tb_led_bar_sequencer.sv
// Bench for led_bar_sequencer: directed cycle table, reset-during-write
// sequence, then randomized traffic against a behavioural model.
module tb_led_bar_sequencer;

    localparam int BD = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  level_in = 4'd0;
    logic        level_valid = 1'b0;
    logic        alarm = 1'b0;
    logic        hold = 1'b0;
    logic [1:0]  pio_address;
    logic        pio_chipselect;
    logic        pio_write_n;
    logic [31:0] pio_writedata;
    logic        busy;
    logic [15:0] write_count;

    int checks = 0;
    int errors = 0;

    led_bar_sequencer #(
        .LED_WIDTH (10),
        .LEVEL_W   (4),
        .BLINK_DIV (BD),
        .PIO_ADDR  (0)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .level_in       (level_in),
        .level_valid    (level_valid),
        .alarm          (alarm),
        .hold           (hold),
        .pio_address    (pio_address),
        .pio_chipselect (pio_chipselect),
        .pio_write_n    (pio_write_n),
        .pio_writedata  (pio_writedata),
        .busy           (busy),
        .write_count    (write_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        lv;
        logic [3:0]  lin;
        logic        al;
        logic        ho;
        logic        cs;
        logic [9:0]  wd;
        logic        bsy;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs[38];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic cs, input logic [9:0] wd,
                              input logic bsy, input logic [15:0] cnt);
        check({tag, ".chipselect"}, {31'd0, pio_chipselect}, {31'd0, cs});
        check({tag, ".write_n"},    {31'd0, pio_write_n},    {31'd0, ~cs});
        check({tag, ".writedata"},  pio_writedata,           {22'd0, wd});
        check({tag, ".busy"},       {31'd0, busy},           {31'd0, bsy});
        check({tag, ".write_count"}, {16'd0, write_count},   {16'd0, cnt});
        check({tag, ".address"},    {30'd0, pio_address},    32'd0);
    endtask

    // Behavioural model: level value, alarm age, pending write stage.
    int          m_level, m_age, m_stage, m_count;
    logic [9:0]  m_shadow, m_wr;

    function automatic logic [9:0] m_target(input logic al);
        if (al) begin
            return (((m_age / BD) % 2) == 0) ? 10'h3FF : 10'h000;
        end else begin
            return 10'((1 << m_level) - 1);
        end
    endfunction

    task automatic model_reset();
        m_level = 0; m_age = 0; m_stage = 0; m_count = 0;
        m_shadow = 10'd0; m_wr = 10'd0;
    endtask

    task automatic model_step(input logic lv, input logic [3:0] lin, input logic al, input logic ho);
        logic [9:0] t;
        t = m_target(al);
        if (m_stage == 0) begin
            if (t != m_shadow && !ho) begin
                m_wr = t;
                m_stage = 1;
            end
        end else if (m_stage == 1) begin
            m_shadow = m_wr;
            m_count = (m_count + 1) % 65536;
            m_stage = 2;
        end else begin
            m_stage = 0;
        end
        if (lv) m_level = (int'(lin) > 10) ? 10 : int'(lin);
        m_age = al ? m_age + 1 : 0;
    endtask

    initial begin
        logic lv_r, al_r, ho_r;
        logic [3:0] lin_r;

        // columns: lv lin alarm hold | cs wd busy count
        vecs[0]  = '{1'b1, 4'd5,  1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 16'd0};
        vecs[1]  = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 16'd0};
        vecs[2]  = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 10'h01F, 1'b1, 16'd0};
        vecs[3]  = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 16'd1};
        vecs[4]  = '{1'b1, 4'd15, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 16'd1};
        vecs[5]  = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 16'd1};
        vecs[6]  = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 10'h3FF, 1'b1, 16'd1};
        vecs[7]  = '{1'b1, 4'd15, 1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 16'd2};
        vecs[8]  = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 16'd2};
        vecs[9]  = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 16'd2};
        vecs[10] = '{1'b1, 4'd3,  1'b0, 1'b1, 1'b0, 10'h000, 1'b0, 16'd2};
        vecs[11] = '{1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 10'h000, 1'b0, 16'd2};
        vecs[12] = '{1'b0, 4'd0,  1'b0, 1'b1, 1'b0, 10'h000, 1'b0, 16'd2};
        vecs[13] = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 16'd2};
        vecs[14] = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 10'h007, 1'b1, 16'd2};
        vecs[15] = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 16'd3};
        vecs[16] = '{1'b1, 4'd2,  1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 16'd3};
        vecs[17] = '{1'b1, 4'd7,  1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 16'd3};
        vecs[18] = '{1'b1, 4'd9,  1'b0, 1'b0, 1'b1, 10'h003, 1'b1, 16'd3};
        vecs[19] = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 16'd4};
        vecs[20] = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 16'd4};
        vecs[21] = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 10'h1FF, 1'b1, 16'd4};
        vecs[22] = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 16'd5};
        vecs[23] = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 10'h000, 1'b0, 16'd5};
        vecs[24] = '{1'b1, 4'd4,  1'b1, 1'b0, 1'b1, 10'h3FF, 1'b1, 16'd5};
        vecs[25] = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 10'h000, 1'b1, 16'd6};
        vecs[26] = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 10'h000, 1'b0, 16'd6};
        vecs[27] = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 10'h000, 1'b0, 16'd6};
        vecs[28] = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 10'h000, 1'b1, 16'd6};
        vecs[29] = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 10'h000, 1'b1, 16'd7};
        vecs[30] = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 10'h000, 1'b0, 16'd7};
        vecs[31] = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 10'h000, 1'b0, 16'd7};
        vecs[32] = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b1, 10'h3FF, 1'b1, 16'd7};
        vecs[33] = '{1'b0, 4'd0,  1'b1, 1'b0, 1'b0, 10'h000, 1'b1, 16'd8};
        vecs[34] = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 16'd8};
        vecs[35] = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b1, 10'h00F, 1'b1, 16'd8};
        vecs[36] = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 10'h000, 1'b1, 16'd9};
        vecs[37] = '{1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 10'h000, 1'b0, 16'd9};

        // Reset state while reset_n is held low.
        repeat (2) @(negedge clk);
        check_outs("reset", 1'b0, 10'h000, 1'b0, 16'd0);
        reset_n = 1'b1;

        // Directed table, one row per clock cycle.
        for (int i = 0; i < 38; i++) begin
            @(negedge clk);
            level_valid = vecs[i].lv;
            level_in    = vecs[i].lin;
            alarm       = vecs[i].al;
            hold        = vecs[i].ho;
            check_outs($sformatf("vec%0d", i), vecs[i].cs, vecs[i].wd, vecs[i].bsy, vecs[i].cnt);
        end

        // Reset arriving during the WRITE cycle drops the strobes at once.
        @(negedge clk);
        level_valid = 1'b1; level_in = 4'd6;
        @(negedge clk);
        level_valid = 1'b0;
        @(negedge clk);
        check_outs("pre_rst_write", 1'b1, 10'h03F, 1'b1, 16'd9);
        reset_n = 1'b0;
        #1;
        check_outs("async_rst", 1'b0, 10'h000, 1'b0, 16'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_outs($sformatf("post_rst%0d", i), 1'b0, 10'h000, 1'b0, 16'd0);
        end

        // Randomized traffic against the model from a fresh reset.
        @(negedge clk);
        reset_n = 1'b0;
        level_valid = 1'b0; alarm = 1'b0; hold = 1'b0; level_in = 4'd0;
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        al_r = 1'b0; ho_r = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            lv_r  = ($urandom_range(0, 2) == 0);
            lin_r = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) al_r = ~al_r;
            if ($urandom_range(0, 9) == 0)  ho_r = ~ho_r;
            level_valid = lv_r; level_in = lin_r; alarm = al_r; hold = ho_r;
            check_outs("rand", (m_stage == 1), (m_stage == 1) ? m_wr : 10'h000,
                       (m_stage != 0), 16'(m_count));
            model_step(lv_r, lin_r, al_r, ho_r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
